// File: rtl/varredor_na.sv
// Open-node scan controller: streams every cost word of the open-node memory
// into the minimum comparator and captures the comparator's final minimum.
module varredor_na #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_COMPARADOR = 8,
    parameter int NUM_GRUPOS     = 4,
    parameter int ADDR_WIDTH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_in,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic [DATA_WIDTH-1:0]                min_out,
    output logic                                 found_out,
    output logic                                 mem_rd_out,
    output logic [ADDR_WIDTH-1:0]                mem_addr_out,
    input  logic [DATA_WIDTH*NUM_COMPARADOR-1:0] mem_data_in,
    output logic                                 iniciar_out,
    output logic                                 atualizar_out,
    output logic [DATA_WIDTH*NUM_COMPARADOR-1:0] cmp_data_out,
    input  logic [DATA_WIDTH-1:0]                cmp_min_in
);

    localparam logic [DATA_WIDTH-1:0] EMPTY = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_GRUPOS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  atualizar_q, atualizar_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic                  mem_rd;
    logic                  iniciar;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        min_d   = min_q;
        found_d = found_q;
        done_d  = 1'b0;
        mem_rd  = 1'b0;
        iniciar = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start_in) state_d = S_INIT;
            end
            S_INIT: begin
                iniciar = 1'b1;
                mem_rd  = 1'b1;
                if (NUM_GRUPOS == 1) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    state_d = S_READ;
                    addr_d  = ADDR_WIDTH'(1);
                end
            end
            S_READ: begin
                mem_rd = 1'b1;
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                min_d   = cmp_min_in;
                found_d = (cmp_min_in != EMPTY);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // read data lags the strobe by one cycle, so the valid flag does too
        atualizar_d = mem_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            atualizar_q <= 1'b0;
            done_q      <= 1'b0;
            min_q       <= EMPTY;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            atualizar_q <= atualizar_d;
            done_q      <= done_d;
            min_q       <= min_d;
            found_q     <= found_d;
        end
    end

    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = done_q;
    assign min_out       = min_q;
    assign found_out     = found_q;
    assign mem_rd_out    = mem_rd;
    assign mem_addr_out  = addr_q;
    assign iniciar_out   = iniciar;
    assign atualizar_out = atualizar_q;
    // the comparator samples every cycle; all-ones filler can never lower its min
    assign cmp_data_out  = atualizar_q ? mem_data_in : '1;

endmodule

// File: tb/tb_varredor_na.sv
// Bench for varredor_na: 1-cycle RAM and running-min comparator models,
// expected minimum taken directly from the memory contents.
module tb_varredor_na;

    localparam int DW = 8;
    localparam int NC = 8;
    localparam int NG = 4;
    localparam int AW = 2;
    localparam int WW = DW * NC;
    localparam logic [WW-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-group instance
    logic          start, busy, done, found, mem_rd, iniciar, atualizar;
    logic [DW-1:0] min_o, cmp_min;
    logic [AW-1:0] addr;
    logic [WW-1:0] rdata, cmp_data;
    logic [WW-1:0] mem [0:NG-1];

    // 1-group instance
    logic          start1, busy1, done1, found1, mem_rd1, iniciar1, atualizar1;
    logic [DW-1:0] min1, cmp_min1;
    logic [0:0]    addr1;
    logic [WW-1:0] rdata1, cmp_data1, mem1w;

    int checks = 0;
    int errors = 0;

    varredor_na #(.DATA_WIDTH(DW), .NUM_COMPARADOR(NC),
                  .NUM_GRUPOS(NG), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .start_in(start), .busy_out(busy),
        .done_out(done), .min_out(min_o), .found_out(found),
        .mem_rd_out(mem_rd), .mem_addr_out(addr), .mem_data_in(rdata),
        .iniciar_out(iniciar), .atualizar_out(atualizar),
        .cmp_data_out(cmp_data), .cmp_min_in(cmp_min)
    );

    varredor_na #(.DATA_WIDTH(DW), .NUM_COMPARADOR(NC),
                  .NUM_GRUPOS(1), .ADDR_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_in(start1), .busy_out(busy1),
        .done_out(done1), .min_out(min1), .found_out(found1),
        .mem_rd_out(mem_rd1), .mem_addr_out(addr1), .mem_data_in(rdata1),
        .iniciar_out(iniciar1), .atualizar_out(atualizar1),
        .cmp_data_out(cmp_data1), .cmp_min_in(cmp_min1)
    );

    function automatic logic [DW-1:0] lane_min(input logic [WW-1:0] w);
        logic [DW-1:0] m;
        m = '1;
        for (int i = 0; i < NC; i++)
            if (w[i*DW +: DW] < m) m = w[i*DW +: DW];
        return m;
    endfunction

    function automatic logic [DW-1:0] ref_min();
        logic [DW-1:0] m;
        m = '1;
        for (int g = 0; g < NG; g++)
            if (lane_min(mem[g]) < m) m = lane_min(mem[g]);
        return m;
    endfunction

    // RAM returns garbage zeros when not read, to expose missing filler
    always @(posedge clk) begin
        rdata  <= mem_rd ? mem[addr] : '0;
        rdata1 <= mem_rd1 ? mem1w : '0;
    end

    initial begin
        cmp_min  = '1;
        cmp_min1 = '1;
    end

    always @(posedge clk) begin
        if (iniciar) cmp_min <= '1;
        else if (lane_min(cmp_data) < cmp_min) cmp_min <= lane_min(cmp_data);
        if (iniciar1) cmp_min1 <= '1;
        else if (lane_min(cmp_data1) < cmp_min1) cmp_min1 <= lane_min(cmp_data1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [WW-1:0] obs, input logic [WW-1:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [WW-1:0] v);
        for (int g = 0; g < NG; g++) mem[g] = v;
    endtask

    // Called at a cycle with busy=0; starts there (T0) and returns at T0+7.
    task automatic scan(input bit hold, input string tag);
        logic [DW-1:0] exp, prev;
        exp   = ref_min();
        prev  = min_o;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk(iniciar, (c == 1), {tag, "_iniciar"});
            chk(done, 0, {tag, "_done_early"});
            chk(busy, 1, {tag, "_busy"});
            chk(min_o, prev, {tag, "_min_held"});
            chk(mem_rd, (c <= 4), {tag, "_rd"});
            if (c <= 4) chk(addr, c - 1, {tag, "_addr"});
            chk(atualizar, (c >= 2 && c <= 5), {tag, "_atualizar"});
            if (c >= 2 && c <= 5) chk(cmp_data, mem[c-2], {tag, "_word"});
            else chk(cmp_data, ONES, {tag, "_filler"});
            if (hold && c == 6) start = 1'b0;
            tick();
        end
        chk(done, 1, {tag, "_done"});
        chk(min_o, exp, {tag, "_min"});
        chk(found, (exp != 8'hFF), {tag, "_found"});
        chk(busy, 0, {tag, "_busy_end"});
        chk(iniciar, 0, {tag, "_iniciar_end"});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        fill(ONES);
        mem1w  = ONES;
        tick();
        tick();
        chk(busy, 0, "rst_busy");
        chk(done, 0, "rst_done");
        chk(min_o, 8'hFF, "rst_min");
        chk(found, 0, "rst_found");
        chk(mem_rd, 0, "rst_rd");
        chk(iniciar, 0, "rst_iniciar");
        chk(atualizar, 0, "rst_atualizar");
        chk(addr, 0, "rst_addr");
        chk(cmp_data, ONES, "rst_filler");
        rst = 1'b0;
        tick();

        // basic scan, then back-to-back restart with a lower cost
        mem[2][5*DW +: DW] = 8'h17;
        mem[0][1*DW +: DW] = 8'h40;
        scan(0, "t1");
        mem[3][0 +: DW] = 8'h03;
        scan(0, "t3");
        tick();
        chk(done, 0, "t3_done_once");

        // all-empty memory
        fill(ONES);
        scan(0, "t2");
        tick();

        // start held high across a whole scan
        mem[1][3*DW +: DW] = 8'h5A;
        scan(1, "t4");
        tick();
        chk(done, 0, "t4_no_second_done");
        chk(busy, 0, "t4_no_requeue");
        chk(iniciar, 0, "t4_no_iniciar");

        // randomized memory contents
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < NG; g++)
                for (int l = 0; l < NC; l++)
                    mem[g][l*DW +: DW] = ($urandom_range(0, 3) == 0) ?
                        DW'($urandom_range(0, 255)) : 8'hFF;
            if (r == 5) fill(ONES);
            scan(0, "rnd");
            if ($urandom_range(0, 1) == 1) tick();
        end

        // reset in the middle of a scan
        mem[0][0 +: DW] = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(busy, 0, "t5_busy");
        chk(mem_rd, 0, "t5_rd");
        chk(iniciar, 0, "t5_iniciar");
        chk(atualizar, 0, "t5_atualizar");
        chk(done, 0, "t5_done");
        chk(min_o, 8'hFF, "t5_min");
        chk(found, 0, "t5_found");
        chk(addr, 0, "t5_addr");
        for (int c = 0; c < 8; c++) begin
            tick();
            chk(done, 0, "t5_no_done");
            chk(busy, 0, "t5_idle");
        end

        // single-group instance
        mem1w = ONES;
        mem1w[7*DW +: DW] = 8'h00;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk(iniciar1, 1, "t6_iniciar");
        chk(mem_rd1, 1, "t6_rd");
        chk(addr1, 0, "t6_addr");
        chk(cmp_data1, ONES, "t6_filler_init");
        tick();
        chk(mem_rd1, 0, "t6_rd_off");
        chk(iniciar1, 0, "t6_iniciar_off");
        chk(atualizar1, 1, "t6_atualizar");
        chk(cmp_data1, mem1w, "t6_word");
        tick();
        chk(done1, 0, "t6_done_early");
        chk(busy1, 1, "t6_busy");
        chk(cmp_data1, ONES, "t6_filler_done");
        tick();
        chk(done1, 1, "t6_done");
        chk(min1, 8'h00, "t6_min");
        chk(found1, 1, "t6_found");
        chk(busy1, 0, "t6_busy_end");
        tick();
        chk(done1, 0, "t6_done_pulse");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
